// File: rtl/mips_mc_pkg.sv
// Shared definitions for the MIPS multicycle CPU: opcodes, control FSM states,
// ALU/mux select encodings and the bundled control word.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BR       = 4'd8,
    S_JMP      = 4'd9,
    S_I_EX     = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_OFFSET = 2'b10,
    SRCB_BRANCH = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BGTZ, OP_J, OP_ADDI: legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational control-word decode from FSM state; mem_ready only gates the
// FETCH load strobes and the final cycle of a store.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore decode of the control word per state
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end else begin
          ctrl.ir_write = 1'b0;
          ctrl.pc_write = 1'b0;
        end
      end
      S_DECODE:   ctrl.alu_src_b = SRCB_BRANCH;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_OFFSET;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_R_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_I_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_OFFSET;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM of the MIPS multicycle CPU: sequences the shared datapath one
// instruction at a time and counts retired instructions.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  state_t           state_r;
  state_t           next_s;
  logic [5:0]       op_r;
  logic [CNT_W-1:0] retired_r;
  ctrl_t            ctrl_s;
  logic             instr_done_s;

  mips_mc_outdec u_outdec (
    .state     (state_r),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  // State register, opcode latch and retired counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_FETCH;
      op_r      <= 6'd0;
      retired_r <= '0;
    end else begin
      state_r <= next_s;
      if (state_r == S_DECODE) begin
        op_r <= opcode;
      end
      if (instr_done_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state logic; MEM_ADDR relies on the opcode latched in DECODE
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_s = S_DECODE;
        else           next_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_s = S_MEM_ADDR;
          OP_RTYPE:     next_s = S_R_EX;
          OP_BGTZ:      next_s = S_BR;
          OP_J:         next_s = S_JMP;
          OP_ADDI:      next_s = S_I_EX;
          default:      next_s = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (op_r == OP_LW) next_s = S_MEM_RD;
        else               next_s = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready) next_s = S_MEM_WB;
        else           next_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) next_s = S_FETCH;
        else           next_s = S_MEM_WR;
      end
      S_R_EX:  next_s = S_R_WB;
      S_I_EX:  next_s = S_I_WB;
      default: next_s = S_FETCH;
    endcase
  end

  // Port drive; reset suppresses every write/request strobe
  always_comb begin
    instr_done_s  = ctrl_s.instr_done & ~rst;
    pc_write      = ctrl_s.pc_write & ~rst;
    pc_write_cond = ctrl_s.pc_write_cond & ~rst;
    ir_write      = ctrl_s.ir_write & ~rst;
    mem_read      = ctrl_s.mem_read & ~rst;
    mem_write     = ctrl_s.mem_write & ~rst;
    reg_write     = ctrl_s.reg_write & ~rst;
    illegal       = (state_r == S_DECODE) & ~is_legal_op(opcode) & ~rst;
    instr_done    = instr_done_s;
    i_or_d        = ctrl_s.i_or_d;
    mem_to_reg    = ctrl_s.mem_to_reg;
    reg_dst       = ctrl_s.reg_dst;
    alu_src_a     = ctrl_s.alu_src_a;
    alu_src_b     = ctrl_s.alu_src_b;
    alu_op        = ctrl_s.alu_op;
    pc_source     = ctrl_s.pc_source;
    state         = state_r;
    retired       = retired_r;
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks each instruction class cycle by cycle
// against hand-written control words, including waits, illegal opcodes and reset.
module tb_mips_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        illegal, instr_done;
  logic [31:0] retired;
  logic [17:0] vec;

  int errors = 0;
  int checks = 0;

  // Control word order: pw pwc iod mr mw irw m2r rdst rw asa | srcb aluop pcsrc | ill done
  localparam logic [17:0] V_RESET   = 18'b0000000000_010000_00;
  localparam logic [17:0] V_FETCH_R = 18'b1001010000_010000_00;
  localparam logic [17:0] V_FETCH_W = 18'b0001000000_010000_00;
  localparam logic [17:0] V_DECODE  = 18'b0000000000_110000_00;
  localparam logic [17:0] V_DEC_ILL = 18'b0000000000_110000_10;
  localparam logic [17:0] V_MADDR   = 18'b0000000001_100000_00;
  localparam logic [17:0] V_MEMRD   = 18'b0011000000_000000_00;
  localparam logic [17:0] V_MEMRD_X = 18'b0010000000_000000_00;
  localparam logic [17:0] V_MEMWB   = 18'b0000001010_000000_01;
  localparam logic [17:0] V_MEMWR_W = 18'b0010100000_000000_00;
  localparam logic [17:0] V_MEMWR_R = 18'b0010100000_000000_01;
  localparam logic [17:0] V_REX     = 18'b0000000001_001000_00;
  localparam logic [17:0] V_RWB     = 18'b0000000110_000000_01;
  localparam logic [17:0] V_BR      = 18'b0100000001_000101_01;
  localparam logic [17:0] V_JMP     = 18'b1000000000_000010_01;
  localparam logic [17:0] V_IEX     = 18'b0000000001_100000_00;
  localparam logic [17:0] V_IWB     = 18'b0000000010_000000_01;

  mips_mc_control #(.CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .illegal       (illegal),
    .instr_done    (instr_done),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  assign vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, instr_done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then check state and control word
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic [5:0] op,
                     input logic [3:0] exp_state, input logic [17:0] exp_vec);
    @(negedge clk);
    rst       = r;
    mem_ready = rdy;
    opcode    = op;
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
    chk({tag, ".ctrl"}, {14'd0, vec}, {14'd0, exp_vec});
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'd0;
    @(posedge clk);
    cyc("reset", 1'b1, 1'b1, 6'b000000, 4'd0, V_RESET);
    chk("reset.retired", retired, 32'd0);

    // LW, zero wait states; opcode input is scrambled after DECODE
    cyc("lw.fetch", 1'b0, 1'b1, 6'b000000, 4'd0, V_FETCH_R);
    cyc("lw.decode", 1'b0, 1'b1, 6'b100011, 4'd1, V_DECODE);
    cyc("lw.maddr", 1'b0, 1'b1, 6'b101011, 4'd2, V_MADDR);
    cyc("lw.memrd", 1'b0, 1'b1, 6'b000000, 4'd3, V_MEMRD);
    cyc("lw.memwb", 1'b0, 1'b1, 6'b000000, 4'd4, V_MEMWB);
    chk("lw.retired_before", retired, 32'd0);

    // SW with two wait states in MEM_WR
    cyc("sw.fetch", 1'b0, 1'b1, 6'b000000, 4'd0, V_FETCH_R);
    chk("lw.retired", retired, 32'd1);
    cyc("sw.decode", 1'b0, 1'b1, 6'b101011, 4'd1, V_DECODE);
    cyc("sw.maddr", 1'b0, 1'b0, 6'b100011, 4'd2, V_MADDR);
    cyc("sw.wait1", 1'b0, 1'b0, 6'b000000, 4'd5, V_MEMWR_W);
    cyc("sw.wait2", 1'b0, 1'b0, 6'b000000, 4'd5, V_MEMWR_W);
    cyc("sw.done", 1'b0, 1'b1, 6'b000000, 4'd5, V_MEMWR_R);

    // BGTZ then J
    cyc("br.fetch", 1'b0, 1'b1, 6'b000000, 4'd0, V_FETCH_R);
    chk("sw.retired", retired, 32'd2);
    cyc("br.decode", 1'b0, 1'b1, 6'b000111, 4'd1, V_DECODE);
    cyc("br.br", 1'b0, 1'b0, 6'b000000, 4'd8, V_BR);
    cyc("j.fetch", 1'b0, 1'b1, 6'b000000, 4'd0, V_FETCH_R);
    cyc("j.decode", 1'b0, 1'b1, 6'b000010, 4'd1, V_DECODE);
    cyc("j.jmp", 1'b0, 1'b0, 6'b000000, 4'd9, V_JMP);

    // Illegal opcode: pulses in DECODE, back to FETCH, no count
    cyc("ill.fetch", 1'b0, 1'b1, 6'b000000, 4'd0, V_FETCH_R);
    chk("brj.retired", retired, 32'd4);
    cyc("ill.decode", 1'b0, 1'b1, 6'b111111, 4'd1, V_DEC_ILL);

    // R-type then ADDI, each with one fetch wait state
    cyc("r.fwait", 1'b0, 1'b0, 6'b000000, 4'd0, V_FETCH_W);
    chk("ill.retired", retired, 32'd4);
    cyc("r.fetch", 1'b0, 1'b1, 6'b000000, 4'd0, V_FETCH_R);
    cyc("r.decode", 1'b0, 1'b1, 6'b000000, 4'd1, V_DECODE);
    cyc("r.ex", 1'b0, 1'b0, 6'b000000, 4'd6, V_REX);
    cyc("r.wb", 1'b0, 1'b0, 6'b000000, 4'd7, V_RWB);
    cyc("i.fwait", 1'b0, 1'b0, 6'b000000, 4'd0, V_FETCH_W);
    cyc("i.fetch", 1'b0, 1'b1, 6'b000000, 4'd0, V_FETCH_R);
    cyc("i.decode", 1'b0, 1'b1, 6'b001000, 4'd1, V_DECODE);
    cyc("i.ex", 1'b0, 1'b0, 6'b000000, 4'd10, V_IEX);
    cyc("i.wb", 1'b0, 1'b0, 6'b000000, 4'd11, V_IWB);

    // Reset during an LW memory-read wait abandons the load
    cyc("rl.fetch", 1'b0, 1'b1, 6'b000000, 4'd0, V_FETCH_R);
    chk("ri.retired", retired, 32'd6);
    cyc("rl.decode", 1'b0, 1'b1, 6'b100011, 4'd1, V_DECODE);
    cyc("rl.maddr", 1'b0, 1'b0, 6'b000000, 4'd2, V_MADDR);
    cyc("rl.wait", 1'b0, 1'b0, 6'b000000, 4'd3, V_MEMRD);
    cyc("rl.rst", 1'b1, 1'b1, 6'b000000, 4'd3, V_MEMRD_X);
    cyc("rl.after", 1'b0, 1'b0, 6'b000000, 4'd0, V_FETCH_W);
    chk("rl.retired", retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Main control FSM for the MIPS multicycle CPU. It sequences the shared datapath (PC, memory, IR, register file, ALU, immediate/offset extender) through fetch, decode, execute, memory and write-back steps, one instruction at a time. Memory accesses use a ready handshake with wait states. The block also counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], sampled in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if datapath branch condition true
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination: 0 = rt, 1 = rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = offset, 11 = offset (branch target)
- alu_op  out  2  00 = add, 01 = compare/sub, 10 = funct-decoded
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state encoding, for debug
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- retired  out  CNT_W  count of completed instructions

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, BR 8, JMP 9, I_EX 10, I_WB 11. Codes 12–15 are unreachable; if entered, the FSM goes to FETCH next cycle with all strobes 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. The FSM holds while mem_ready=0. In the cycle mem_ready=1, ir_write=1 and pc_write=1, and the next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - LW 100011 or SW 101011 → MEM_ADDR
  - R-type 000000 → R_EX
  - BGTZ 000111 → BR
  - J 000010 → JMP
  - ADDI 001000 → I_EX
  - any other opcode → FETCH, with illegal=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for LW, MEM_WR for SW. The opcode is latched in DECODE; the opcode input is not re-read here.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready; the cycle mem_ready=1 is the final cycle, then FETCH.
- R_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BR: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next is FETCH.
- JMP: pc_write=1, pc_source=10. Next is FETCH.
- I_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next is I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- Any output not listed for a state is 0 in that state.
- instr_done is high on the final cycle of each instruction: MEM_WB, MEM_WR with mem_ready=1, R_WB, BR, JMP, I_WB.
- retired increments by 1 on each instr_done and wraps modulo 2^CNT_W. An illegal opcode does not count.

## Timing
- Outputs are Moore-decoded from state. The only exception is gating by mem_ready in FETCH (pc_write, ir_write), MEM_WR (instr_done) and the wait transitions.
- Cycles per instruction with zero wait states: LW 5, SW 4, R-type 4, ADDI 4, BGTZ 3, J 3.
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready is ignored in all other states.
- Reset: on the clock edge with rst=1, state becomes FETCH, retired becomes 0 and the latched opcode becomes 0.
  - While rst=1, all write/request strobes are forced to 0: pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, illegal, instr_done.
  - Reset mid-instruction, including during a memory wait, abandons the instruction without a write or a count.
  - The first fetch begins the cycle after rst falls.
- rst has priority over every other event on the same edge.

## Structure
- Shared package mips_mc_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BGTZ, OP_J, OP_ADDI
  - the state enum
  - alu_op, alu_src_b and pc_source encodings
- The package is shared with the datapath and the offset extender.
- One sub-module, mips_mc_outdec: purely combinational mapping from state and mem_ready to control outputs. The FSM, opcode latch and counter stay in the top level.

## Test plan
- Reset then LW with mem_ready tied to 1 → states 0,1,2,3,4. reg_write and mem_to_reg are high in cycle 5. instr_done pulses once, and retired=1.
- SW with mem_ready low for 2 cycles in MEM_WR → mem_write is high for 3 cycles, then 0 writes to the register file. Total 6 cycles.
- BGTZ then J → BR has pc_write_cond=1 and pc_source=01. JMP has pc_write=1 and pc_source=10. Each takes 3 cycles; retired goes +2.
- Opcode 111111 → illegal pulses in DECODE, the next state is FETCH, and retired is unchanged.
- rst asserted during MEM_RD wait → next state is FETCH, no reg_write, retired=0.
- Back-to-back R-type and ADDI with 1 fetch wait state each → reg_dst=1 then 0 in the write-back states. ir_write pulses only in the mem_ready cycle.
